// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: commits results to A/X/Y/SP/P and issues
// memory writes (plain store or RMW old-then-new double write) over req/ack.
module alu_writeback #(
    parameter logic [7:0] P_RESET  = 8'h34,
    parameter logic [7:0] SP_RESET = 8'hFD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_dest,
    input  logic        wb_flag_en,
    input  logic [7:0]  alu_out,
    input  logic [7:0]  alu_next_status,
    input  logic [7:0]  alu_old,
    input  logic [15:0] wb_addr,
    input  logic        p_load,
    input  logic [7:0]  p_load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_x,
    output logic [7:0]  reg_y,
    output logic [7:0]  reg_sp,
    output logic [7:0]  reg_p
);

    localparam logic [2:0] D_A   = 3'd1;
    localparam logic [2:0] D_X   = 3'd2;
    localparam logic [2:0] D_Y   = 3'd3;
    localparam logic [2:0] D_SP  = 3'd4;
    localparam logic [2:0] D_ST  = 3'd5;
    localparam logic [2:0] D_RMW = 3'd6;

    typedef enum logic [1:0] {IDLE, STORE, RMW_DUMMY, RMW_FINAL} state_t;

    state_t     state, state_nxt;
    logic       accept;
    logic [7:0] fin_data;

    assign wb_ready = (state == IDLE);
    assign accept   = wb_valid && wb_ready;
    // Request comes straight from the state register so reset drops it asynchronously.
    assign mem_req  = (state != IDLE);
    assign mem_we   = mem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && wb_dest == D_ST)  state_nxt = STORE;
                if (accept && wb_dest == D_RMW) state_nxt = RMW_DUMMY;
            end
            STORE:     if (mem_ack) state_nxt = IDLE;
            RMW_DUMMY: if (mem_ack) state_nxt = RMW_FINAL;
            RMW_FINAL: if (mem_ack) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bus address/data are registered at accept and held for the whole request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            fin_data  <= '0;
        end else if (accept && wb_dest == D_ST) begin
            mem_addr  <= wb_addr;
            mem_wdata <= alu_out;
        end else if (accept && wb_dest == D_RMW) begin
            mem_addr  <= wb_addr;
            mem_wdata <= alu_old;
            fin_data  <= alu_out;
        end else if (state == RMW_DUMMY && mem_ack) begin
            mem_wdata <= fin_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a  <= '0;
            reg_x  <= '0;
            reg_y  <= '0;
            reg_sp <= SP_RESET;
        end else if (accept) begin
            case (wb_dest)
                D_A:     reg_a  <= alu_out;
                D_X:     reg_x  <= alu_out;
                D_Y:     reg_y  <= alu_out;
                D_SP:    reg_sp <= alu_out;
                default: ;
            endcase
        end
    end

    // Direct P load wins over the ALU flag commit; bit 5 always reads as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   reg_p <= P_RESET | 8'h20;
        else if (p_load)              reg_p <= p_load_data | 8'h20;
        else if (accept && wb_flag_en) reg_p <= alu_next_status | 8'h20;
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback: register/flag commit,
// store and RMW bus sequences, P priority, busy-ignore and mid-write reset.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_ready, wb_flag_en, p_load, mem_req, mem_we, mem_ack;
    logic [2:0]  wb_dest;
    logic [7:0]  alu_out, alu_next_status, alu_old, p_load_data, mem_wdata;
    logic [7:0]  reg_a, reg_x, reg_y, reg_sp, reg_p;
    logic [15:0] wb_addr, mem_addr;

    int pass_cnt = 0;
    int total    = 0;

    alu_writeback #(.P_RESET(8'h34), .SP_RESET(8'hFD)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest(wb_dest), .wb_flag_en(wb_flag_en), .alu_out(alu_out),
        .alu_next_status(alu_next_status), .alu_old(alu_old), .wb_addr(wb_addr),
        .p_load(p_load), .p_load_data(p_load_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y),
        .reg_sp(reg_sp), .reg_p(reg_p)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_valid = 0; wb_dest = 0; wb_flag_en = 0; alu_out = 0;
        alu_next_status = 0; alu_old = 0; wb_addr = 0; p_load = 0;
        p_load_data = 0; mem_ack = 0;
        #12;
        total++; if (reg_p !== 8'h34) $display("FAIL reset_p got=%h exp=34", reg_p); else pass_cnt++;
        total++; if (reg_sp !== 8'hFD) $display("FAIL reset_sp got=%h exp=fd", reg_sp); else pass_cnt++;
        total++; if ({reg_a, reg_x, reg_y} !== 24'h0) $display("FAIL reset_axy got=%h exp=0", {reg_a, reg_x, reg_y}); else pass_cnt++;
        total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'h0) $display("FAIL reset_bus got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total++; if (wb_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", wb_ready); else pass_cnt++;
    endtask

    task automatic test_regs();
        wb_valid = 1; wb_dest = 3'd1; alu_out = 8'h80; wb_flag_en = 1; alu_next_status = 8'h80;
        tick();
        total++; if (reg_a !== 8'h80) $display("FAIL reg_a got=%h exp=80", reg_a); else pass_cnt++;
        total++; if (reg_p !== 8'hA0) $display("FAIL flag_p got=%h exp=a0", reg_p); else pass_cnt++;
        wb_flag_en = 0;
        wb_dest = 3'd2; alu_out = 8'h11; tick();
        wb_dest = 3'd3; alu_out = 8'h22; tick();
        wb_dest = 3'd4; alu_out = 8'h33; tick();
        wb_dest = 3'd7; alu_out = 8'hFF; tick();
        wb_dest = 3'd0; alu_out = 8'hEE; tick();
        wb_valid = 0;
        total++; if ({reg_x, reg_y, reg_sp} !== 24'h112233) $display("FAIL reg_xysp got=%h exp=112233", {reg_x, reg_y, reg_sp}); else pass_cnt++;
        total++; if (reg_a !== 8'h80) $display("FAIL noop_a got=%h exp=80", reg_a); else pass_cnt++;
        total++; if (reg_p !== 8'hA0) $display("FAIL noflag_p got=%h exp=a0", reg_p); else pass_cnt++;
        total++; if (mem_req !== 1'b0) $display("FAIL noop_req got=%b exp=0", mem_req); else pass_cnt++;
    endtask

    task automatic test_store();
        mem_ack = 0;
        wb_valid = 1; wb_dest = 3'd5; wb_addr = 16'h0200; alu_out = 8'h5A;
        wb_flag_en = 1; alu_next_status = 8'h01;
        tick();
        wb_valid = 0; wb_flag_en = 0;
        total++; if (reg_p !== 8'h21) $display("FAIL store_flag got=%h exp=21", reg_p); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({mem_req, mem_we, wb_ready, mem_addr, mem_wdata} !== {3'b110, 16'h0200, 8'h5A})
                $display("FAIL store_cyc%0d got req=%b we=%b rdy=%b a=%h d=%h exp 1 1 0 0200 5a",
                         i, mem_req, mem_we, wb_ready, mem_addr, mem_wdata);
            else pass_cnt++;
            if (i == 3) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        total++; if ({mem_req, wb_ready} !== 2'b01) $display("FAIL store_done got req=%b rdy=%b exp 0 1", mem_req, wb_ready); else pass_cnt++;
    endtask

    task automatic test_rmw();
        logic [7:0]  wd [4];
        logic [15:0] wa [4];
        int          nw = 0;
        mem_ack = 1;
        wb_valid = 1; wb_dest = 3'd6; wb_addr = 16'h00FF; alu_old = 8'h7F; alu_out = 8'hFE;
        tick();
        // Upstream presenting a new op while busy must be ignored.
        wb_dest = 3'd1; alu_out = 8'h99;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) wb_valid = 0;
            if (mem_req && mem_ack) begin
                if (nw < 4) begin wd[nw] = mem_wdata; wa[nw] = mem_addr; end
                nw++;
                total++; if (wb_ready !== 1'b0) $display("FAIL rmw_ready_busy got=%b exp=0", wb_ready); else pass_cnt++;
            end
            tick();
        end
        mem_ack = 0;
        total++; if (nw !== 2) $display("FAIL rmw_count got=%0d exp=2", nw); else pass_cnt++;
        if (nw >= 2) begin
            total++; if ({wa[0], wd[0]} !== {16'h00FF, 8'h7F}) $display("FAIL rmw_first got=%h/%h exp=00ff/7f", wa[0], wd[0]); else pass_cnt++;
            total++; if ({wa[1], wd[1]} !== {16'h00FF, 8'hFE}) $display("FAIL rmw_second got=%h/%h exp=00ff/fe", wa[1], wd[1]); else pass_cnt++;
        end
        total++; if (reg_a !== 8'h80) $display("FAIL busy_ignore got=%h exp=80", reg_a); else pass_cnt++;
        total++; if ({mem_req, wb_ready} !== 2'b01) $display("FAIL rmw_done got req=%b rdy=%b exp 0 1", mem_req, wb_ready); else pass_cnt++;
    endtask

    task automatic test_p_priority();
        p_load = 1; p_load_data = 8'h03;
        wb_valid = 1; wb_dest = 3'd0; wb_flag_en = 1; alu_next_status = 8'hC0;
        tick();
        p_load = 0; wb_valid = 0; wb_flag_en = 0;
        total++; if (reg_p !== 8'h23) $display("FAIL p_priority got=%h exp=23", reg_p); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        mem_ack = 0;
        wb_valid = 1; wb_dest = 3'd6; wb_addr = 16'h1234; alu_old = 8'h11; alu_out = 8'h22;
        tick();
        wb_valid = 0; mem_ack = 1;
        tick();
        mem_ack = 0;
        total++; if ({mem_req, mem_wdata} !== {1'b1, 8'h22}) $display("FAIL rmw_final got req=%b d=%h exp 1 22", mem_req, mem_wdata); else pass_cnt++;
        #1 rst_n = 0;
        #1;
        total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'h0) $display("FAIL abort_bus got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata}); else pass_cnt++;
        total++; if ({reg_a, reg_x, reg_y, reg_sp, reg_p} !== 40'h000000FD34) $display("FAIL abort_regs got=%h exp=000000fd34", {reg_a, reg_x, reg_y, reg_sp, reg_p}); else pass_cnt++;
        #3 rst_n = 1;
        tick();
        total++; if ({mem_req, wb_ready} !== 2'b01) $display("FAIL after_reset got req=%b rdy=%b exp 0 1", mem_req, wb_ready); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_store();
        test_rmw();
        test_p_priority();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
